// File: rtl/io_bank_ctrl.sv
// IO bank controller: pad direction control, synchronized/debounced pad inputs,
// heartbeat output and a multiplexed 7-segment display scanner.
module io_bank_ctrl #(
  parameter int NUM_IOS         = 8,
  parameter int NUM_INPUTS      = 4,
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int HEARTBEAT_BIT   = 25,
  parameter int NUM_OF_ANODES   = 4,
  parameter int SCAN_CYCLES     = 12500
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic [NUM_IOS-1:0]         I_top,
  input  logic [NUM_IOS-1:0]         T_top,
  output logic [NUM_IOS-1:0]         O_top,
  input  logic [NUM_IOS-1:0]         pad_i,
  output logic [NUM_IOS-1:0]         pad_o,
  output logic [NUM_IOS-1:0]         pad_oe,
  input  logic                       seg_en,
  input  logic [4*NUM_OF_ANODES-1:0] seg_digits,
  output logic [NUM_OF_ANODES-1:0]   an,
  output logic [6:0]                 seg,
  output logic                       heartbeat
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int SCAN_W = $clog2(SCAN_CYCLES);
  localparam int IDX_W  = (NUM_OF_ANODES > 1) ? $clog2(NUM_OF_ANODES) : 1;

  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(NUM_OF_ANODES - 1);
  localparam logic [NUM_IOS-1:0] IN_MASK =
    {{(NUM_IOS-NUM_INPUTS){1'b0}}, {NUM_INPUTS{1'b1}}};

  logic [NUM_IOS-1:0]       r_sync1;
  logic [NUM_IOS-1:0]       r_sync2;
  logic [NUM_INPUTS-1:0]    r_stable;
  logic [DB_W-1:0]          r_db_cnt [NUM_INPUTS];
  logic [HEARTBEAT_BIT:0]   r_hb_cnt;
  logic [SCAN_W-1:0]        r_scan_cnt;
  logic [IDX_W-1:0]         r_idx;
  logic [3:0]               w_nibble;
  logic [NUM_OF_ANODES-1:0] w_an;
  logic [6:0]               w_seg_dec;

  // Input-only channels never drive their pads
  assign pad_o  = I_top & ~IN_MASK;
  assign pad_oe = T_top & ~IN_MASK;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pad_i;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_stable <= '0;
      for (int unsigned k = 0; k < NUM_INPUTS; k++) r_db_cnt[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
        if (r_sync2[k] == r_stable[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_MAX) begin
          r_stable[k] <= r_sync2[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    O_top                   = r_sync2;
    O_top[NUM_INPUTS-1:0]   = r_stable;
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) r_hb_cnt <= '0;
    else         r_hb_cnt <= r_hb_cnt + 1'b1;
  end

  assign heartbeat = r_hb_cnt[HEARTBEAT_BIT];

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (r_scan_cnt == SCAN_MAX) begin
      r_scan_cnt <= '0;
      r_idx      <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  always_comb begin
    w_nibble = '0;
    w_an     = '1;
    for (int unsigned k = 0; k < NUM_OF_ANODES; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nibble = seg_digits[4*k +: 4];
        w_an[k]  = 1'b0;
      end
    end
  end

  // Active-low {g,f,e,d,c,b,a}
  always_comb begin
    w_seg_dec = 7'h7F;
    case (w_nibble)
      4'h0: w_seg_dec = 7'h40;
      4'h1: w_seg_dec = 7'h79;
      4'h2: w_seg_dec = 7'h24;
      4'h3: w_seg_dec = 7'h30;
      4'h4: w_seg_dec = 7'h19;
      4'h5: w_seg_dec = 7'h12;
      4'h6: w_seg_dec = 7'h02;
      4'h7: w_seg_dec = 7'h78;
      4'h8: w_seg_dec = 7'h00;
      4'h9: w_seg_dec = 7'h10;
      4'hA: w_seg_dec = 7'h08;
      4'hB: w_seg_dec = 7'h03;
      4'hC: w_seg_dec = 7'h46;
      4'hD: w_seg_dec = 7'h21;
      4'hE: w_seg_dec = 7'h06;
      4'hF: w_seg_dec = 7'h0E;
      default: w_seg_dec = 7'h7F;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      an  <= '1;
      seg <= 7'h7F;
    end else if (seg_en) begin
      an  <= w_an;
      seg <= w_seg_dec;
    end else begin
      an  <= '1;
      seg <= 7'h7F;
    end
  end

endmodule

// File: doc/io_bank_ctrl.md
IO_BANK_CTRL -- requirements
Module: io_bank_ctrl

Interface
REQ-001 SHALL have parameter NUM_IOS, default 8: total user IO channels.
REQ-002 SHALL have parameter NUM_INPUTS, default 4: channels 0..NUM_INPUTS-1 are input-only (switches); 1 <= NUM_INPUTS < NUM_IOS.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 125000: stable cycles required before an input change is accepted (10 ms at 12.5 MHz); minimum 2.
REQ-004 SHALL have parameter HEARTBEAT_BIT, default 25: heartbeat counter bit driven to the heartbeat output.
REQ-005 SHALL have parameter NUM_OF_ANODES, default 4: 7-segment digits scanned.
REQ-006 SHALL have parameter SCAN_CYCLES, default 12500: clock cycles per digit; minimum 2.
REQ-007 SHALL have ports, in this order:
  CLK  in  1  sole clock, fabric clock domain
  resetn  in  1  reset, asynchronous assert, active-low
  I_top  in  NUM_IOS  fabric output data per channel
  T_top  in  NUM_IOS  fabric drive enable, 1 = drive pad
  O_top  out  NUM_IOS  data to fabric
  pad_i  in  NUM_IOS  raw pad input, asynchronous
  pad_o  out  NUM_IOS  pad output data
  pad_oe  out  NUM_IOS  pad output enable, 1 = drive
  seg_en  in  1  display enable
  seg_digits  in  4*NUM_OF_ANODES  hex nibble per digit, digit 0 in bits [3:0]
  an  out  NUM_OF_ANODES  anodes, active-low
  seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
  heartbeat  out  1  liveness indicator

Function
REQ-008 Channels i < NUM_INPUTS: pad_oe[i] SHALL be 0 and pad_o[i] SHALL be 0 regardless of I_top/T_top.
REQ-009 Channels i >= NUM_INPUTS: pad_o[i] = I_top[i], pad_oe[i] = T_top[i], combinational.
REQ-010 Every pad_i bit SHALL pass through a 2-flop synchronizer.
REQ-011 Channels i >= NUM_INPUTS: O_top[i] SHALL equal the 2nd synchronizer flop (2-cycle latency, no debounce).
REQ-012 Channels i < NUM_INPUTS: one debounce counter and stable flop per channel; O_top[i] = stable flop.
REQ-013 Debounce: sync == stable -> counter cleared; sync != stable and counter < DEBOUNCE_CYCLES-1 -> counter+1; sync != stable and counter == DEBOUNCE_CYCLES-1 -> stable <= sync, counter <= 0.
REQ-014 A pad change held steady SHALL appear on O_top exactly 2+DEBOUNCE_CYCLES rising edges after its first sampling edge; a pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never reach O_top.
REQ-015 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES); no overflow is reachable.
REQ-016 Heartbeat counter SHALL be HEARTBEAT_BIT+1 bits, free-running, wrapping to 0; heartbeat = counter[HEARTBEAT_BIT] (period 2^(HEARTBEAT_BIT+1) cycles, 50% duty).
REQ-017 Scan counter SHALL count 0..SCAN_CYCLES-1 and wrap; on wrap digit index SHALL advance by 1, wrapping NUM_OF_ANODES-1 -> 0.
REQ-018 Scan counter and index SHALL run regardless of seg_en.
REQ-019 an and seg SHALL be registered, reflecting index and seg_digits of the previous cycle (1-cycle latency).
REQ-020 seg_en=1: an = one-hot-low at index; seg = active-low hex decode of nibble at index (0->0x40, 1->0x79, 8->0x00, A->0x08, F->0x0E; full 0-F set, A-F as A b C d E F).
REQ-021 seg_en=0: an = all ones, seg = 0x7F, from the next edge.
REQ-022 Exactly one anode SHALL be low at any time while seg_en=1; never more than one.

Reset
REQ-023 resetn low SHALL asynchronously clear synchronizers, stable flops, debounce, heartbeat and scan counters and index to 0; an = all ones, seg = 0x7F, heartbeat = 0, O_top = 0.
REQ-024 Reset asserted mid-debounce SHALL discard the pending change; after release the channel restarts from stable = 0.
REQ-025 First active edge after resetn release SHALL be the first counting edge of every counter.

Verification
REQ-026 DEBOUNCE_CYCLES=4: pad_i[0] 0->1 held -> O_top[0] rises on the 6th edge, not the 5th.
REQ-027 DEBOUNCE_CYCLES=4: pad_i[1] 3-cycle high pulse -> O_top[1] stays 0; 4-cycle pulse -> O_top[1] pulses high.
REQ-028 pad_i[5] toggled, T_top[5]=1, I_top[5]=1 -> pad_oe[5]=1, pad_o[5]=1, O_top[5] follows pad_i[5] after 2 edges; T_top[2]=1 -> pad_oe[2]=0.
REQ-029 HEARTBEAT_BIT=3 -> heartbeat 0 for 8 edges, 1 for 8 edges, repeating from reset.
REQ-030 SCAN_CYCLES=3, seg_digits=16'hF810, seg_en=1 -> an cycles 1110,1101,1011,0111 every 3 edges with seg 0x40,0x79,0x00,0x0E; seg_en=0 -> an=1111, seg=0x7F next edge.
REQ-031 resetn pulsed low mid-scan and mid-debounce -> all outputs immediately at reset values; index restarts at 0.
